// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data memory arbiter
package dmem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_D = 1'b1
   } port_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side bundle for the core (C) and DMA/debug (D) ports
interface dmem_arbiter_if
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              c_req;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_gnt;
   logic              c_rvalid;
   logic [DATA_W-1:0] c_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output d_req, d_we, d_addr, d_wdata,
      input  c_gnt, c_rvalid, c_rdata,
      input  d_gnt, d_rvalid, d_rdata
   );

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  d_req, d_we, d_addr, d_wdata,
      output c_gnt, c_rvalid, c_rdata,
      output d_gnt, d_rvalid, d_rdata
   );
endinterface

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-way picker, round-robin or fixed C-first priority
module dmem_rr_pick
   import dmem_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic  c_req,
   input  logic  d_req,
   input  port_t rr_ptr,
   output port_t winner,
   output logic  valid
);
   always_comb begin
      valid  = c_req | d_req;
      winner = PORT_C;
      // rr_ptr names the port that wins the next contention
      if (c_req && d_req)
         winner = (FIXED_PRIO != 0) ? PORT_C : rr_ptr;
      else if (d_req)
         winner = PORT_D;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between core (C) and DMA/debug (D) ports
// DMEM_ARB_STATS_EN adds saturating grant and conflict counters.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     bus,
   output logic [ADDR_W-1:0] mem_read_addr,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ren_wen,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_c_grants,
   output logic [15:0]       stat_d_grants,
   output logic [15:0]       stat_conflicts
`endif
);
   state_t            state, state_nx;
   port_t             rr_ptr, cmd_port, pick_winner;
   logic              pick_valid;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              c_gnt, d_gnt;
   logic              c_rvalid, d_rvalid;
   logic [DATA_W-1:0] c_rdata, d_rdata;

   dmem_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
      .c_req  (bus.c_req),
      .d_req  (bus.d_req),
      .rr_ptr (rr_ptr),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rr_ptr    <= PORT_C;
         cmd_port  <= PORT_C;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         c_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         c_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         state    <= state_nx;
         c_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         if (state == ST_IDLE && pick_valid) begin
            cmd_port  <= pick_winner;
            cmd_we    <= (pick_winner == PORT_C) ? bus.c_we    : bus.d_we;
            cmd_addr  <= (pick_winner == PORT_C) ? bus.c_addr  : bus.d_addr;
            cmd_wdata <= (pick_winner == PORT_C) ? bus.c_wdata : bus.d_wdata;
         end
         if (state == ST_ACCESS) begin
            // the port just served yields priority on the next contention
            rr_ptr <= (cmd_port == PORT_C) ? PORT_D : PORT_C;
            if (!cmd_we && cmd_port == PORT_C) begin
               c_rdata  <= mem_rdata;
               c_rvalid <= 1'b1;
            end
            if (!cmd_we && cmd_port == PORT_D) begin
               d_rdata  <= mem_rdata;
               d_rvalid <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nx       = state;
      c_gnt          = 1'b0;
      d_gnt          = 1'b0;
      mem_read_addr  = '0;
      mem_write_addr = '0;
      mem_wdata      = '0;
      mem_ren_wen    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid)
               state_nx = ST_ACCESS;
         end
         ST_ACCESS: begin
            state_nx       = ST_IDLE;
            c_gnt          = (cmd_port == PORT_C);
            d_gnt          = (cmd_port == PORT_D);
            mem_read_addr  = cmd_addr;
            mem_write_addr = cmd_addr;
            mem_wdata      = cmd_wdata;
            // a reset landing mid-access must not commit the write
            mem_ren_wen    = cmd_we & rst_n;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign bus.c_gnt    = c_gnt;
   assign bus.d_gnt    = d_gnt;
   assign bus.c_rvalid = c_rvalid;
   assign bus.d_rvalid = d_rvalid;
   assign bus.c_rdata  = c_rdata;
   assign bus.d_rdata  = d_rdata;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_c_grants  <= '0;
         stat_d_grants  <= '0;
         stat_conflicts <= '0;
      end else begin
         if (c_gnt)
            stat_c_grants <= sat_inc16(stat_c_grants);
         if (d_gnt)
            stat_d_grants <= sat_inc16(stat_d_grants);
         if (state == ST_IDLE && bus.c_req && bus.d_req)
            stat_conflicts <= sat_inc16(stat_conflicts);
      end
   end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench; round-robin and fixed-priority instances share one stimulus
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if bus ();
   dmem_arbiter_if fbus ();

   assign fbus.c_req   = bus.c_req;
   assign fbus.c_we    = bus.c_we;
   assign fbus.c_addr  = bus.c_addr;
   assign fbus.c_wdata = bus.c_wdata;
   assign fbus.d_req   = bus.d_req;
   assign fbus.d_we    = bus.d_we;
   assign fbus.d_addr  = bus.d_addr;
   assign fbus.d_wdata = bus.d_wdata;

   logic [7:0] a_raddr, a_waddr, a_wdata, a_rdata;
   logic [7:0] b_raddr, b_waddr, b_wdata, b_rdata;
   logic       a_wen, b_wen;
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];

   always @(posedge clk) if (a_wen) mem_a[a_waddr] <= a_wdata;
   always @(posedge clk) if (b_wen) mem_b[b_waddr] <= b_wdata;
   assign a_rdata = mem_a[a_raddr];
   assign b_rdata = mem_b[b_raddr];

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] a_sc, a_sd, a_conf, b_sc, b_sd, b_conf;
`endif

   dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus.slave),
      .mem_read_addr  (a_raddr),
      .mem_write_addr (a_waddr),
      .mem_wdata      (a_wdata),
      .mem_ren_wen    (a_wen),
      .mem_rdata      (a_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_c_grants  (a_sc),
      .stat_d_grants  (a_sd),
      .stat_conflicts (a_conf)
`endif
   );

   dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (fbus.slave),
      .mem_read_addr  (b_raddr),
      .mem_write_addr (b_waddr),
      .mem_wdata      (b_wdata),
      .mem_ren_wen    (b_wen),
      .mem_rdata      (b_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_c_grants  (b_sc),
      .stat_d_grants  (b_sd),
      .stat_conflicts (b_conf)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_c_gnt"},    bus.c_gnt, 0);
      check({tag, "_d_gnt"},    bus.d_gnt, 0);
      check({tag, "_c_rvalid"}, bus.c_rvalid, 0);
      check({tag, "_d_rvalid"}, bus.d_rvalid, 0);
      check({tag, "_c_rdata"},  bus.c_rdata, 0);
      check({tag, "_d_rdata"},  bus.d_rdata, 0);
      check({tag, "_wen"},      a_wen, 0);
      check({tag, "_raddr"},    a_raddr, 0);
      check({tag, "_waddr"},    a_waddr, 0);
      check({tag, "_wdata"},    a_wdata, 0);
`ifdef DMEM_ARB_STATS_EN
      check({tag, "_stat_c"},    a_sc, 0);
      check({tag, "_stat_d"},    a_sd, 0);
      check({tag, "_stat_conf"}, a_conf, 0);
`endif
   endtask

   // Caller must be sitting in an IDLE cycle; returns in the rvalid cycle (also IDLE).
   task automatic do_access(input string tag, input logic port, input logic we,
                            input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] exp_rd);
      if (port == PORT_C) begin
         bus.c_req = 1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
      end else begin
         bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      end
      step();
      // scramble the command during ACCESS: latched values must be unaffected
      bus.c_req = 0; bus.d_req = 0;
      bus.c_addr = ~addr; bus.d_addr = ~addr; bus.c_wdata = ~wdata; bus.d_wdata = ~wdata;
      #1;
      check({tag, "_c_gnt"},  bus.c_gnt, (port == PORT_C));
      check({tag, "_d_gnt"},  bus.d_gnt, (port == PORT_D));
      check({tag, "_fp_gnt"}, {fbus.d_gnt, fbus.c_gnt}, (port == PORT_C) ? 2'b01 : 2'b10);
      check({tag, "_wen"},    a_wen, we);
      check({tag, "_waddr"},  a_waddr, addr);
      check({tag, "_raddr"},  a_raddr, addr);
      if (we)
         check({tag, "_wdata"}, a_wdata, wdata);
      step();
      check({tag, "_c_rvalid"}, bus.c_rvalid, (port == PORT_C) && !we);
      check({tag, "_d_rvalid"}, bus.d_rvalid, (port == PORT_D) && !we);
      if (!we)
         check({tag, "_rdata"}, (port == PORT_C) ? bus.c_rdata : bus.d_rdata, exp_rd);
   endtask

   // contention table, cycles 1..10: bit0 = C granted, bit1 = D granted
   logic [1:0] rr_g [0:10] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
   logic [1:0] fp_g [0:10] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

   initial begin
      int sum_before;
      int sum_after;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      mem_a[1] = 8'h11; mem_a[2] = 8'h22;
      mem_b[1] = 8'h11; mem_b[2] = 8'h22;
      idle_bus();

      rst_n = 0;
      repeat (3) step();
      check_reset_outputs("rst");
      rst_n = 1;
      step();

      // contention: C reads 01, D reads 02, both held
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h01;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h02;
      for (int i = 1; i <= 10; i++) begin
         step();
         check($sformatf("rr_gnt_%0d", i), {bus.d_gnt, bus.c_gnt}, rr_g[i]);
         check($sformatf("fp_gnt_%0d", i), {fbus.d_gnt, fbus.c_gnt}, fp_g[i]);
         check($sformatf("rr_rv_%0d", i), {bus.d_rvalid, bus.c_rvalid}, rr_g[i-1]);
         check($sformatf("fp_rv_%0d", i), {fbus.d_rvalid, fbus.c_rvalid}, fp_g[i-1]);
         if (rr_g[i-1][0]) check($sformatf("rr_crd_%0d", i), bus.c_rdata, 8'h11);
         if (rr_g[i-1][1]) check($sformatf("rr_drd_%0d", i), bus.d_rdata, 8'h22);
         if (fp_g[i-1][0]) check($sformatf("fp_crd_%0d", i), fbus.c_rdata, 8'h11);
         if (fp_g[i-1][1]) check($sformatf("fp_drd_%0d", i), fbus.d_rdata, 8'h22);
         if (i == 8)  bus.c_req = 0;
         if (i == 10) bus.d_req = 0;
      end
`ifdef DMEM_ARB_STATS_EN
      check("stat_rr_c",    a_sc, 2);
      check("stat_rr_d",    a_sd, 3);
      check("stat_rr_conf", a_conf, 4);
      check("stat_fp_c",    b_sc, 4);
      check("stat_fp_d",    b_sd, 1);
      check("stat_fp_conf", b_conf, 4);
`endif

      // single-port write/read, address extremes
      do_access("c_wr10", PORT_C, 1, 8'h10, 8'hA5, 8'h00);
      do_access("c_rd10", PORT_C, 0, 8'h10, 8'h00, 8'hA5);
      check("mem10", mem_a[8'h10], 8'hA5);
      do_access("d_wrff", PORT_D, 1, 8'hFF, 8'h3C, 8'h00);
      do_access("d_rdff", PORT_D, 0, 8'hFF, 8'h00, 8'h3C);
      check("memff", mem_a[8'hFF], 8'h3C);
      do_access("c_rd00", PORT_C, 0, 8'h00, 8'h00, 8'h00);
      check("d_rdata_held", bus.d_rdata, 8'h3C);

      // reset lands in the ACCESS cycle of a D write
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h20; bus.d_wdata = 8'h5A;
      step();
      check("rstw_gnt", bus.d_gnt, 1);
      check("rstw_wen_pre", a_wen, 1);
      rst_n = 0;
      bus.d_req = 0;
      #1;
      check("rstw_wen_sup", a_wen, 0);
      step();
      check_reset_outputs("rstw");
      check("rstw_mem20", mem_a[8'h20], 8'h00);
      rst_n = 1;
      step();
      do_access("c_rd20", PORT_C, 0, 8'h20, 8'h00, 8'h00);

      // idle bus with wandering command fields
      sum_before = 0;
      for (int i = 0; i < 256; i++) sum_before += int'(mem_a[i]) * (i + 1);
      for (int i = 0; i < 10; i++) begin
         bus.c_we = 1; bus.d_we = 1;
         bus.c_addr = 8'($urandom); bus.c_wdata = 8'($urandom);
         bus.d_addr = 8'($urandom); bus.d_wdata = 8'($urandom);
         step();
         check($sformatf("idle_wen_%0d", i), a_wen, 0);
         check($sformatf("idle_gnt_%0d", i), {bus.d_gnt, bus.c_gnt}, 2'b00);
         check($sformatf("idle_rv_%0d", i), {bus.d_rvalid, bus.c_rvalid}, 2'b00);
         check($sformatf("idle_waddr_%0d", i), a_waddr, 0);
      end
      sum_after = 0;
      for (int i = 0; i < 256; i++) sum_after += int'(mem_a[i]) * (i + 1);
      check("idle_mem_sum", sum_after, sum_before);
      check("idle_mem10", mem_a[8'h10], 8'hA5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
